// File: rtl/kernel_loader_pkg.sv
// Shared definitions for the kernel loader: FSM encoding and word geometry.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package kernel_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Stream beats needed to fill one packed memory word.
    function automatic int calc_beats(input int group_nb, input int ker_width,
                                      input int depth_nb, input int str_width);
        return (group_nb * ker_width * depth_nb) / str_width;
    endfunction

    // Counter width that stays legal when the count collapses to one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kernel_pack.sv
// Packs STR_WIDTH stream beats little-endian into one BEATS*STR_WIDTH word.
// Latency: word valid one cycle after its final beat is accepted.
// Backpressure: non-final beats always accepted while en; final beat waits for a free output slot.
//
// Ports: clk/rst; en (loader is in LOAD); str_data/str_val/str_rdy input stream;
//        wr_data/wr_data_val/wr_data_rdy output word; word_done pulses when a final beat is taken.
module kernel_pack
    import kernel_loader_pkg::*;
#(
    parameter int STR_WIDTH = 64,
    parameter int BEATS     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [STR_WIDTH-1:0]       str_data,
    input  logic                       str_val,
    output logic                       str_rdy,
    output logic [STR_WIDTH*BEATS-1:0] wr_data,
    output logic                       wr_data_val,
    input  logic                       wr_data_rdy,
    output logic                       word_done
);

    localparam int W  = STR_WIDTH * BEATS;
    localparam int BW = cnt_width(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    logic [BW-1:0] beat_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  word_next;
    logic          last_beat;
    logic          accept;

    assign last_beat = (beat_q == LAST_BEAT);
    // Only the completing beat needs the output register to be free.
    assign str_rdy   = en & (~last_beat | ~wr_data_val | wr_data_rdy);
    assign accept    = str_val & str_rdy;
    assign word_done = accept & last_beat;

    always_comb begin
        word_next = acc_q;
        word_next[beat_q*STR_WIDTH +: STR_WIDTH] = str_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q      <= '0;
            acc_q       <= '0;
            wr_data     <= '0;
            wr_data_val <= 1'b0;
        end else begin
            if (accept) begin
                acc_q  <= word_next;
                beat_q <= last_beat ? '0 : beat_q + 1'b1;
            end
            // A new word in the handshake cycle keeps valid high: no bubble.
            if (word_done) begin
                wr_data     <= word_next;
                wr_data_val <= 1'b1;
            end else if (wr_data_rdy) begin
                wr_data_val <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/kernel_loader.sv
// Loads a region of N packed kernel words into memory and reports the address range written.
// Latency: wr_cfg_set one cycle after command; done one cycle after the last word handshake.
// Backpressure: cmd_rdy only in IDLE; stream stalls on final beats while the output word is held.
//
// Ports: clk/rst; cmd_words/cmd_val/cmd_rdy region command; str_data/str_val/str_rdy kernel stream;
//        wr_cfg_end/wr_cfg_set write bound; wr_data/wr_data_val/wr_data_rdy packed words;
//        done_start/done_end/done loaded-region report.
module kernel_loader
    import kernel_loader_pkg::*;
#(
    parameter int GROUP_NB   = 4,
    parameter int KER_WIDTH  = 16,
    parameter int DEPTH_NB   = 16,
    parameter int STR_WIDTH  = 64,
    parameter int MEM_AWIDTH = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [MEM_AWIDTH-1:0]                   cmd_words,
    input  logic                                    cmd_val,
    output logic                                    cmd_rdy,
    input  logic [STR_WIDTH-1:0]                    str_data,
    input  logic                                    str_val,
    output logic                                    str_rdy,
    output logic [MEM_AWIDTH-1:0]                   wr_cfg_end,
    output logic                                    wr_cfg_set,
    output logic [GROUP_NB*KER_WIDTH*DEPTH_NB-1:0]  wr_data,
    output logic                                    wr_data_val,
    input  logic                                    wr_data_rdy,
    output logic [MEM_AWIDTH-1:0]                   done_start,
    output logic [MEM_AWIDTH-1:0]                   done_end,
    output logic                                    done
);

    localparam int BEATS = calc_beats(GROUP_NB, KER_WIDTH, DEPTH_NB, STR_WIDTH);
    localparam logic [MEM_AWIDTH-1:0] ONE = MEM_AWIDTH'(1);

    state_t                state_q, state_d;
    logic [MEM_AWIDTH-1:0] end_q, base_q, words_q, word_cnt_q, end_next;
    logic                  pack_en, word_done, last_word, cmd_acc, out_hs;

    assign cmd_acc   = cmd_val & (state_q == IDLE);
    assign out_hs    = wr_data_val & wr_data_rdy;
    assign last_word = (word_cnt_q == words_q - ONE);
    assign end_next  = end_q + cmd_words;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cmd_rdy = 1'b0;
        pack_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_rdy = ~rst;
                if (cmd_val && cmd_words != '0) state_d = LOAD;
            end
            LOAD: begin
                pack_en = 1'b1;
                if (word_done && last_word) state_d = DRAIN;
            end
            DRAIN: begin
                // Only the last word can still be pending here.
                if (out_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            end_q      <= '0;
            base_q     <= '0;
            words_q    <= '0;
            word_cnt_q <= '0;
            wr_cfg_set <= 1'b0;
            wr_cfg_end <= '0;
            done       <= 1'b0;
            done_start <= '0;
            done_end   <= '0;
        end else begin
            wr_cfg_set <= 1'b0;
            done       <= 1'b0;
            if (cmd_acc) begin
                if (cmd_words != '0) begin
                    base_q     <= end_q;
                    end_q      <= end_next;
                    words_q    <= cmd_words;
                    word_cnt_q <= '0;
                    wr_cfg_set <= 1'b1;
                    wr_cfg_end <= end_next;
                end else begin
                    // Empty region: report it at the current bound.
                    done       <= 1'b1;
                    done_start <= end_q;
                    done_end   <= end_q;
                end
            end
            if (state_q == LOAD && word_done) word_cnt_q <= word_cnt_q + ONE;
            if (state_q == DRAIN && out_hs) begin
                done       <= 1'b1;
                done_start <= base_q;
                done_end   <= end_q - ONE;
            end
        end
    end

    kernel_pack #(
        .STR_WIDTH (STR_WIDTH),
        .BEATS     (BEATS)
    ) u_pack (
        .clk         (clk),
        .rst         (rst),
        .en          (pack_en),
        .str_data    (str_data),
        .str_val     (str_val),
        .str_rdy     (str_rdy),
        .wr_data     (wr_data),
        .wr_data_val (wr_data_val),
        .wr_data_rdy (wr_data_rdy),
        .word_done   (word_done)
    );

endmodule
